// File: rtl/dcache_ctrl_pkg.sv
// Shared constants and controller state encoding for the direct-mapped data cache.
package dcache_ctrl_pkg;

    localparam int OFF_W    = 4;   // byte offset bits within one 16-byte block
    localparam int WSEL_LSB = 2;   // word select starts above the byte-in-word bits

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_FILL_WAIT,
        S_FL_SCAN,
        S_FL_WB,
        S_DONE
    } state_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid/dirty/tag/data with one async read port
// and one full-line write port. Only valid and dirty are cleared by reset.
module dcache_array
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int TAG_W      = 24,
    parameter int BLOCK_SIZE = 128,
    parameter int IDX_W      = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_SIZE-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [BLOCK_SIZE-1:0] wr_data
);

    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [BLOCK_SIZE-1:0] data_mem [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_valid;
            dirty[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with a
// flush sequence that writes back every dirty line before raising flush_done.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 128,
    parameter int LINES      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [WORD_SIZE-1:0]  cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    output logic                  cpu_ready,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLOCK_SIZE-1:0] mem_wdata,
    input  logic [BLOCK_SIZE-1:0] mem_rdata,
    input  logic                  flush,
    output logic                  flush_done
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
    localparam int WSEL_W = $clog2(BLOCK_SIZE / WORD_SIZE);

    state_t state, next_state;

    logic [IDX_W-1:0]      req_idx, scan_idx, scan_idx_next, rd_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [WSEL_W-1:0]     word_sel;
    logic                  line_valid, line_dirty, hit;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_SIZE-1:0] line_data;

    logic                  wr_en, wr_valid, wr_dirty;
    logic [IDX_W-1:0]      wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic [BLOCK_SIZE-1:0] wr_data;

    logic                  ready_next, read_next, write_next, done_next;
    logic [WORD_SIZE-1:0]  rdata_next, addr_next;
    logic [BLOCK_SIZE-1:0] wdata_next;
    logic                  unused_addr_bits;

    // Word 0 sits in the most significant bits of the block.
    function automatic logic [WORD_SIZE-1:0] get_word(input logic [BLOCK_SIZE-1:0] blk,
                                                      input logic [WSEL_W-1:0]     w);
        return blk[BLOCK_SIZE-1-WORD_SIZE*int'(w) -: WORD_SIZE];
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0] blk,
                                                      input logic [WSEL_W-1:0]     w,
                                                      input logic [WORD_SIZE-1:0]  d);
        logic [BLOCK_SIZE-1:0] r;
        r = blk;
        r[BLOCK_SIZE-1-WORD_SIZE*int'(w) -: WORD_SIZE] = d;
        return r;
    endfunction

    assign req_idx          = cpu_addr[OFF_W +: IDX_W];
    assign req_tag          = cpu_addr[WORD_SIZE-1 -: TAG_W];
    assign word_sel         = cpu_addr[WSEL_LSB +: WSEL_W];
    assign unused_addr_bits = ^cpu_addr[WSEL_LSB-1:0];

    // The flush walk owns the read port; otherwise it follows the CPU address.
    assign rd_idx = (state == S_FL_SCAN || state == S_FL_WB) ? scan_idx : req_idx;
    assign hit    = line_valid && (line_tag == req_tag);

    dcache_array #(
        .LINES      (LINES),
        .TAG_W      (TAG_W),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            scan_idx   <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= next_state;
            scan_idx   <= scan_idx_next;
            cpu_ready  <= ready_next;
            cpu_rdata  <= rdata_next;
            mem_read   <= read_next;
            mem_write  <= write_next;
            mem_addr   <= addr_next;
            mem_wdata  <= wdata_next;
            flush_done <= done_next;
        end
    end

    // Memory strobes are registered, so they are computed for the state being entered.
    always_comb begin
        next_state    = state;
        scan_idx_next = scan_idx;
        wr_en         = 1'b0;
        wr_idx        = req_idx;
        wr_valid      = line_valid;
        wr_dirty      = line_dirty;
        wr_tag        = line_tag;
        wr_data       = line_data;
        ready_next    = 1'b0;
        rdata_next    = cpu_rdata;
        read_next     = 1'b0;
        write_next    = 1'b0;
        addr_next     = mem_addr;
        wdata_next    = mem_wdata;
        done_next     = flush_done;

        case (state)
            S_IDLE: begin
                if (flush) begin
                    next_state    = S_FL_SCAN;
                    scan_idx_next = '0;
                end else if (cpu_req && !cpu_ready) begin
                    if (hit) begin
                        ready_next = 1'b1;
                        if (cpu_we) begin
                            wr_en    = 1'b1;
                            wr_dirty = 1'b1;
                            wr_data  = put_word(line_data, word_sel, cpu_wdata);
                        end else begin
                            rdata_next = get_word(line_data, word_sel);
                        end
                    end else if (line_valid && line_dirty) begin
                        next_state = S_WB;
                        write_next = 1'b1;
                        addr_next  = {line_tag, req_idx, {OFF_W{1'b0}}};
                        wdata_next = line_data;
                    end else begin
                        next_state = S_FILL;
                        read_next  = 1'b1;
                        addr_next  = {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
            end
            S_WB: begin
                next_state = S_FILL;
                read_next  = 1'b1;
                addr_next  = {req_tag, req_idx, {OFF_W{1'b0}}};
            end
            S_FILL: begin
                next_state = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                wr_en      = 1'b1;
                wr_valid   = 1'b1;
                wr_dirty   = 1'b0;
                wr_tag     = req_tag;
                wr_data    = mem_rdata;
                next_state = S_IDLE;
            end
            S_FL_SCAN: begin
                if (line_valid && line_dirty) begin
                    next_state = S_FL_WB;
                    write_next = 1'b1;
                    addr_next  = {line_tag, scan_idx, {OFF_W{1'b0}}};
                    wdata_next = line_data;
                end else if (scan_idx == IDX_W'(LINES - 1)) begin
                    next_state = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    scan_idx_next = scan_idx + IDX_W'(1);
                end
            end
            S_FL_WB: begin
                wr_en    = 1'b1;
                wr_idx   = scan_idx;
                wr_dirty = 1'b0;
                if (scan_idx == IDX_W'(LINES - 1)) begin
                    next_state = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    next_state    = S_FL_SCAN;
                    scan_idx_next = scan_idx + IDX_W'(1);
                end
            end
            S_DONE: begin
                next_state = S_DONE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: block memory model plus a word-level
// golden view and a tag/valid/dirty reference used to predict latency and traffic.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [31:0]  mem_addr;
    logic         mem_read, mem_write;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         flush = 1'b0;
    logic         flush_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int both_cnt = 0;

    logic [127:0] mem    [bit [31:0]];
    logic [31:0]  golden [bit [31:0]];
    logic [31:0]  wr_addr_q[$];
    logic [127:0] wr_data_q[$];
    int           wr_cyc_q[$];
    logic [31:0]  rd_addr_q[$];
    int           rd_cyc_q[$];

    bit           mv[16];
    bit           md[16];
    logic [23:0]  mt[16];
    logic [31:0]  last_rdata;

    always #5 clk = ~clk;

    dcache_ctrl #(.WORD_SIZE(32), .BLOCK_SIZE(128), .LINES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .flush_done (flush_done)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) * 32'h0001_0001 + 32'h0F0F_1357;
    endfunction

    function automatic logic [127:0] mem_block(input logic [31:0] ba);
        if (mem.exists(ba)) return mem[ba];
        return {init_word(ba), init_word(ba + 4), init_word(ba + 8), init_word(ba + 12)};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0]  wa;
        logic [127:0] b;
        wa = {a[31:2], 2'b00};
        if (golden.exists(wa)) return golden[wa];
        b = mem_block({a[31:4], 4'h0});
        return b[127 - 32*int'(a[3:2]) -: 32];
    endfunction

    function automatic logic [127:0] ref_block(input logic [31:0] ba);
        return {ref_word(ba), ref_word(ba + 4), ref_word(ba + 8), ref_word(ba + 12)};
    endfunction

    // Block memory: a read returns the block on the next rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_read && mem_write) both_cnt++;
            if (mem_write) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                wr_cyc_q.push_back(cyc);
                mem[mem_addr] = mem_wdata;
            end
            if (mem_read) begin
                rd_addr_q.push_back(mem_addr);
                rd_cyc_q.push_back(cyc);
                mem_rdata <= mem_block(mem_addr);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
        golden.delete();
        last_rdata = '0;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
        if (cpu_ready) begin
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!cpu_ready && lat < 20);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
    endtask

    // Predicts one access from cache-level rules: hit = 1 cycle, clean miss = 4, dirty miss = 5.
    task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                                output int lat, output logic [31:0] data,
                                output bit wb, output logic [31:0] wb_addr,
                                output logic [127:0] wb_data, output bit fill,
                                output logic [31:0] fill_addr);
        int idx;
        idx = int'(a[7:4]);
        wb = 1'b0;
        fill = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        fill_addr = '0;
        if (mv[idx] && mt[idx] == a[31:8]) begin
            lat = 1;
        end else begin
            if (mv[idx] && md[idx]) begin
                wb = 1'b1;
                wb_addr = {mt[idx], a[7:4], 4'h0};
                wb_data = ref_block(wb_addr);
                lat = 5;
            end else begin
                lat = 4;
            end
            fill = 1'b1;
            fill_addr = {a[31:4], 4'h0};
            mv[idx] = 1'b1;
            mt[idx] = a[31:8];
            md[idx] = 1'b0;
        end
        if (we) begin
            golden[{a[31:2], 2'b00}] = d;
            md[idx] = 1'b1;
            data = last_rdata;
        end else begin
            data = ref_word(a);
            last_rdata = data;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({cpu_ready, mem_read, mem_write, flush_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000", {cpu_ready, mem_read, mem_write, flush_done});
        end
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        n_tests++;
        if (cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", cpu_rdata);
        end
        n_tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        n_tests++;
        if ({cpu_ready, mem_read, mem_write, flush_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_strobes: got %b want 0000", {cpu_ready, mem_read, mem_write, flush_done});
        end
    endtask

    task automatic test_miss_hit();
        logic [31:0] rd;
        int lat;
        mem[32'h40] = 128'h11111111_22222222_33333333_44444444;
        access(1'b0, 32'h40, 32'h0, rd, lat);
        n_tests++;
        if (lat !== 4 || rd !== 32'h11111111) begin
            n_fail++;
            $display("FAIL clean_miss: got lat %0d data %h want lat 4 data 11111111", lat, rd);
        end
        n_tests++;
        if (rd_addr_q.size() !== 1 || wr_addr_q.size() !== 0 || rd_addr_q[0] !== 32'h40) begin
            n_fail++;
            $display("FAIL fill_traffic: got %0d reads %0d writes want one read of 00000040", rd_addr_q.size(), wr_addr_q.size());
        end
        access(1'b0, 32'h4C, 32'h0, rd, lat);
        n_tests++;
        if (lat !== 1 || rd !== 32'h44444444 || rd_addr_q.size() !== 1) begin
            n_fail++;
            $display("FAIL load_hit: got lat %0d data %h reads %0d want lat 1 data 44444444 reads 1", lat, rd, rd_addr_q.size());
        end
        access(1'b1, 32'h44, 32'hDEADBEEF, rd, lat);
        n_tests++;
        if (lat !== 1 || rd !== 32'h44444444) begin
            n_fail++;
            $display("FAIL store_hit: got lat %0d rdata %h want lat 1 rdata 44444444", lat, rd);
        end
        access(1'b0, 32'h44, 32'h0, rd, lat);
        n_tests++;
        if (lat !== 1 || rd !== 32'hDEADBEEF || wr_addr_q.size() !== 0) begin
            n_fail++;
            $display("FAIL load_after_store: got lat %0d data %h writes %0d want lat 1 data deadbeef writes 0", lat, rd, wr_addr_q.size());
        end
        access(1'b0, 32'h140, 32'h0, rd, lat);
        n_tests++;
        if (lat !== 5 || rd !== init_word(32'h140)) begin
            n_fail++;
            $display("FAIL dirty_miss: got lat %0d data %h want lat 5 data %h", lat, rd, init_word(32'h140));
        end
        n_tests++;
        if (wr_addr_q.size() !== 1 || rd_addr_q.size() !== 2) begin
            n_fail++;
            $display("FAIL dirty_miss_traffic: got %0d writes %0d reads want 1 write 2 reads", wr_addr_q.size(), rd_addr_q.size());
        end else begin
            n_tests++;
            if (wr_addr_q[0] !== 32'h40 || wr_data_q[0] !== 128'h11111111_DEADBEEF_33333333_44444444) begin
                n_fail++;
                $display("FAIL writeback: got addr %h data %h want 00000040 11111111deadbeef3333333344444444", wr_addr_q[0], wr_data_q[0]);
            end
            n_tests++;
            if (rd_addr_q[1] !== 32'h140 || rd_cyc_q[1] !== wr_cyc_q[0] + 1) begin
                n_fail++;
                $display("FAIL refill_after_wb: got addr %h at cycle %0d want 00000140 at cycle %0d", rd_addr_q[1], rd_cyc_q[1], wr_cyc_q[0] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] addrs[3];
        logic [31:0] exp;
        int lat, n;
        addrs[0] = 32'h48;
        addrs[1] = 32'h4C;
        addrs[2] = 32'h40;
        do_reset();
        access(1'b0, 32'h40, 32'h0, rd, lat);
        access(1'b1, 32'h48, 32'hCAFEF00D, rd, lat);
        // Request is raised during the ready cycle, so the first edge must be ignored.
        for (int i = 0; i < 3; i++) begin
            exp = (addrs[i] == 32'h48) ? 32'hCAFEF00D : ref_word(addrs[i]);
            cpu_req = 1'b1;
            cpu_we = 1'b0;
            cpu_addr = addrs[i];
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!cpu_ready && n < 10);
            n_tests++;
            if (n !== 2) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles want 2", i, n);
            end
            n_tests++;
            if (cpu_rdata !== exp) begin
                n_fail++;
                $display("FAIL b2b_data_%0d: got %h want %h", i, cpu_rdata, exp);
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_random();
        logic [23:0]  tags[5];
        logic [31:0]  a, d, rd, exp_data, wb_addr, fill_addr;
        logic [127:0] wb_data;
        logic         we;
        bit           wb, fill;
        int           lat, exp_lat, w0, r0;
        tags[0] = 24'h000000;
        tags[1] = 24'h000001;
        tags[2] = 24'h000002;
        tags[3] = 24'h800001;
        tags[4] = 24'hFFFFFF;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            we = ($urandom_range(0, 9) < 4);
            a = {tags[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            d = $urandom;
            model_access(we, a, d, exp_lat, exp_data, wb, wb_addr, wb_data, fill, fill_addr);
            w0 = wr_addr_q.size();
            r0 = rd_addr_q.size();
            access(we, a, d, rd, lat);
            n_tests++;
            if (lat !== exp_lat || rd !== exp_data) begin
                n_fail++;
                $display("FAIL rand_%0d we=%b addr %h: got lat %0d data %h want lat %0d data %h", i, we, a, lat, rd, exp_lat, exp_data);
            end
            n_tests++;
            if (wr_addr_q.size() - w0 !== int'(wb) || rd_addr_q.size() - r0 !== int'(fill)) begin
                n_fail++;
                $display("FAIL rand_traffic_%0d: got %0d writes %0d reads want %0d writes %0d reads", i, wr_addr_q.size() - w0, rd_addr_q.size() - r0, wb, fill);
            end else begin
                if (wb) begin
                    n_tests++;
                    if (wr_addr_q[w0] !== wb_addr || wr_data_q[w0] !== wb_data) begin
                        n_fail++;
                        $display("FAIL rand_wb_%0d: got %h %h want %h %h", i, wr_addr_q[w0], wr_data_q[w0], wb_addr, wb_data);
                    end
                end
                if (fill) begin
                    n_tests++;
                    if (rd_addr_q[r0] !== fill_addr) begin
                        n_fail++;
                        $display("FAIL rand_fill_%0d: got %h want %h", i, rd_addr_q[r0], fill_addr);
                    end
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0]  rd;
        logic [127:0] blk2, blk9;
        int lat, n, readies;
        do_reset();
        access(1'b1, 32'h1320, 32'h0BADF00D, rd, lat);
        golden[32'h1320] = 32'h0BADF00D;
        access(1'b1, 32'h0590, 32'h600DCAFE, rd, lat);
        golden[32'h0590] = 32'h600DCAFE;
        access(1'b0, 32'h0050, 32'h0, rd, lat);
        blk2 = ref_block(32'h1320);
        blk9 = ref_block(32'h0590);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        if (cpu_ready) begin
            @(posedge clk);
            #1;
        end
        // Flush and a missing load arrive together; the flush must win.
        flush = 1'b1;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h7770;
        n = 0;
        readies = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (cpu_ready) readies++;
        end while (!flush_done && n < 60);
        n_tests++;
        if (n !== 19) begin
            n_fail++;
            $display("FAIL flush_done_time: got %0d cycles want 19", n);
        end
        n_tests++;
        if (wr_addr_q.size() !== 2 || rd_addr_q.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_traffic: got %0d writes %0d reads want 2 writes 0 reads", wr_addr_q.size(), rd_addr_q.size());
        end else begin
            n_tests++;
            if (wr_addr_q[0] !== 32'h1320 || wr_data_q[0] !== blk2) begin
                n_fail++;
                $display("FAIL flush_wb_idx2: got %h %h want 00001320 %h", wr_addr_q[0], wr_data_q[0], blk2);
            end
            n_tests++;
            if (wr_addr_q[1] !== 32'h0590 || wr_data_q[1] !== blk9) begin
                n_fail++;
                $display("FAIL flush_wb_idx9: got %h %h want 00000590 %h", wr_addr_q[1], wr_data_q[1], blk9);
            end
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            if (cpu_ready) readies++;
        end
        flush = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (readies !== 0 || flush_done !== 1'b1 || rd_addr_q.size() !== 0) begin
            n_fail++;
            $display("FAIL done_ignores_cpu: got %0d ready pulses done=%b reads %0d want 0 pulses done=1 reads 0", readies, flush_done, rd_addr_q.size());
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic [31:0] a;
        int lat, n;
        a = 32'h00AB0060;
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            if (ph == 0) begin
                n_tests++;
                if (flush_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_clears_done: got %b want 0", flush_done);
                end
            end
            cpu_req = 1'b1;
            cpu_we = 1'b0;
            cpu_addr = a;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!mem_read && n < 10);
            n_tests++;
            if (mem_read !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_fill_seen_%0d: got mem_read %b want 1", ph, mem_read);
            end
            if (ph == 1) begin
                @(posedge clk);
                #1;
            end
            #2;
            rst = 1'b1;
            cpu_req = 1'b0;
            #1;
            n_tests++;
            if ({mem_read, mem_write, cpu_ready} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_strobes_%0d: got %b want 000", ph, {mem_read, mem_write, cpu_ready});
            end
            @(posedge clk);
            #1 rst = 1'b0;
            clear_model();
            access(1'b0, a, 32'h0, rd, lat);
            n_tests++;
            if (lat !== 4 || rd !== ref_word(a) || rd_addr_q.size() !== 1) begin
                n_fail++;
                $display("FAIL abort_replay_%0d: got lat %0d data %h reads %0d want lat 4 data %h reads 1", ph, lat, rd, rd_addr_q.size(), ref_word(a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_abort();
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL strobe_exclusive: got %0d cycles with both strobes want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
